// File: rtl/data_memory_block_pkg.sv
// Shared types and constants for the block-granular data memory behind the data cache.
// ADDR_W and BLOCK_BYTES defaults must stay in step with the cache's mem_* interface.
package data_memory_block_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    localparam int DEFAULT_ADDR_W      = 6;
    localparam int DEFAULT_BLOCK_BYTES = 4;
    localparam int CNT_W               = 8;

endpackage

// File: rtl/data_mem_array.sv
// Byte-addressed storage with one synchronous block write port, one registered
// block read port and a synchronous clear. BLOCK_BYTES must be a power of two.
module data_mem_array #(
    parameter int ADDR_W      = 6,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [8*BLOCK_BYTES-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [8*BLOCK_BYTES-1:0] rd_data
);

    localparam int LANE_W = $clog2(BLOCK_BYTES);
    localparam int BYTE_AW = ADDR_W + LANE_W;
    localparam int DEPTH = 2 ** BYTE_AW;

    logic [7:0]               mem_bytes_reg [DEPTH];
    logic [8*BLOCK_BYTES-1:0] rd_word;
    logic [8*BLOCK_BYTES-1:0] rd_data_reg;

    // Byte k of a block lives at byte address {block, k}: little-endian in the word.
    generate
        for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_rd_lane
            assign rd_word[8*gi +: 8] = mem_bytes_reg[{rd_addr, LANE_W'(gi)}];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_bytes_reg[i] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                mem_bytes_reg[{wr_addr, LANE_W'(k)}] <= wr_data[8*k +: 8];
            end
        end
    end

    // Read data only moves on a read completion, so it holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= rd_word;
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/data_memory_block.sv
// Main data memory: multi-cycle block read/write behind the data cache, with a
// fixed busy latency followed by one turnaround cycle before new requests are taken.
module data_memory_block
    import data_memory_block_pkg::*;
#(
    parameter int ADDR_W        = DEFAULT_ADDR_W,
    parameter int BLOCK_BYTES   = DEFAULT_BLOCK_BYTES,
    parameter int ACCESS_CYCLES = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [ADDR_W-1:0]        mem_address,
    input  logic [8*BLOCK_BYTES-1:0] mem_writedata,
    output logic [8*BLOCK_BYTES-1:0] mem_readdata,
    output logic                     mem_busywait
);

    mem_state_t               state_reg;
    mem_state_t               state_next;
    logic [CNT_W-1:0]         cnt_reg;
    logic                     op_write_reg;
    logic [ADDR_W-1:0]        addr_reg;
    logic [8*BLOCK_BYTES-1:0] wdata_reg;
    logic                     accept;
    logic                     commit;

    always_comb begin
        state_next   = state_reg;
        mem_busywait = 1'b0;
        accept       = 1'b0;
        commit       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_read || mem_write) begin
                    mem_busywait = 1'b1;
                    accept       = 1'b1;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                mem_busywait = 1'b1;
                if (cnt_reg == '0) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end
            end
            // Turnaround: the cache still sees its request asserted here and must not restart.
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            op_write_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                // A simultaneous read and write request is serviced as a write.
                op_write_reg <= mem_write;
                addr_reg     <= mem_address;
                wdata_reg    <= mem_writedata;
                cnt_reg      <= CNT_W'(ACCESS_CYCLES - 1);
            end else if (state_reg == BUSY && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    data_mem_array #(
        .ADDR_W      (ADDR_W),
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (commit && op_write_reg),
        .wr_addr (addr_reg),
        .wr_data (wdata_reg),
        .rd_en   (commit && !op_write_reg),
        .rd_addr (addr_reg),
        .rd_data (mem_readdata)
    );

endmodule

// File: tb/tb_data_memory_block.sv
// Directed bench for data_memory_block: scoreboard of expected read blocks,
// one instance at the default latency and one at a single-cycle latency.
module tb_data_memory_block;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0, w0, r1, w1;
    logic [5:0]  a0, a1;
    logic [31:0] d0, d1, q0, q1;
    logic        b0, b1;

    data_memory_block #(.ADDR_W(6), .BLOCK_BYTES(4), .ACCESS_CYCLES(5)) dut (
        .clk(clk), .reset(reset), .mem_read(r0), .mem_write(w0),
        .mem_address(a0), .mem_writedata(d0), .mem_readdata(q0), .mem_busywait(b0)
    );

    data_memory_block #(.ADDR_W(6), .BLOCK_BYTES(4), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .mem_read(r1), .mem_write(w1),
        .mem_address(a1), .mem_writedata(d1), .mem_readdata(q1), .mem_busywait(b1)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model0 [64];
    logic [31:0] model1 [64];
    logic [31:0] exp_q [$];
    logic [31:0] last0, last1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic busy(input bit u);
        return u ? b1 : b0;
    endfunction

    function automatic logic [31:0] rdata(input bit u);
        return u ? q1 : q0;
    endfunction

    task automatic drive(input bit u, input bit rd, input bit wr,
                         input logic [5:0] a, input logic [31:0] d);
        if (u) begin
            r1 = rd; w1 = wr; a1 = a; d1 = d;
        end else begin
            r0 = rd; w0 = wr; a0 = a; d0 = d;
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 64; i++) begin
            model0[i] = '0;
            model1[i] = '0;
        end
        last0 = '0;
        last1 = '0;
    endtask

    // Drive a request for cycle 0; reads push the block they must return.
    task automatic issue(input bit u, input bit rd, input bit wr,
                         input logic [5:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        drive(u, rd, wr, a, d);
        if (wr) begin
            if (u) model1[a] = d; else model0[a] = d;
        end else if (rd) begin
            exp_q.push_back(u ? model1[a] : model0[a]);
        end
    endtask

    // Count busy cycles up to the DONE cycle, then check read data or that it held.
    task automatic wait_done(input bit u, input string tag, input int exp_n, input bit is_read);
        int n = 0;
        logic [31:0] e;
        repeat (60) begin
            @(negedge clk);
            if (busy(u)) n++;
            else break;
        end
        chk({tag, "_busy"}, 32'(n), 32'(exp_n));
        if (is_read) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_sb"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_data"}, rdata(u), e);
                if (u) last1 = e; else last0 = e;
            end
        end else begin
            chk({tag, "_hold"}, rdata(u), u ? last1 : last0);
        end
    endtask

    task automatic release_req(input bit u, input string tag);
        @(posedge clk); #1;
        drive(u, 1'b0, 1'b0, 6'h00, 32'h0);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy(u)), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 6'h00, 32'h0);
        drive(1, 0, 0, 6'h00, 32'h0);
        clear_models();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy0", 32'(b0), 32'd0);
        chk("rst_busy1", 32'(b1), 32'd0);
        chk("rst_q0", q0, 32'h0);
        chk("rst_q1", q1, 32'h0);

        // Read of a cleared block: 6 busy cycles then zero data.
        issue(0, 1, 0, 6'h05, 32'h0);
        wait_done(0, "rd05", 6, 1);
        release_req(0, "rd05");

        // Write then read back, with a byte-level look at the storage.
        issue(0, 0, 1, 6'h2A, 32'hDDCCBBAA);
        wait_done(0, "wr2a", 6, 0);
        release_req(0, "wr2a");
        issue(0, 1, 0, 6'h2A, 32'h0);
        wait_done(0, "rd2a", 6, 1);
        release_req(0, "rd2a");
        chk("byte168", {24'h0, dut.u_array.mem_bytes_reg[168]}, 32'h000000AA);
        chk("byte171", {24'h0, dut.u_array.mem_bytes_reg[171]}, 32'h000000DD);

        // Inputs change in cycle 2 of a write; the latched copies must win.
        issue(0, 0, 1, 6'h10, 32'h12345678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a0 = 6'h01;
        d0 = 32'h0;
        wait_done(0, "wr10", 4, 0);
        release_req(0, "wr10");
        issue(0, 1, 0, 6'h10, 32'h0);
        wait_done(0, "rd10", 6, 1);
        release_req(0, "rd10");
        issue(0, 1, 0, 6'h01, 32'h0);
        wait_done(0, "rd01", 6, 1);
        release_req(0, "rd01");

        // Cache-style: request held through DONE, then a fresh access from IDLE.
        issue(0, 1, 0, 6'h2A, 32'h0);
        wait_done(0, "b2b_a", 6, 1);
        exp_q.push_back(model0[6'h2A]);
        wait_done(0, "b2b_b", 6, 1);
        release_req(0, "b2b");

        // Reset in cycle 3 of a write aborts it and clears storage.
        @(posedge clk); #1;
        drive(0, 0, 1, 6'h3F, 32'hFFFFFFFF);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 0, 0, 6'h00, 32'h0);
        clear_models();
        @(negedge clk);
        chk("rstw_busy", 32'(b0), 32'd0);
        chk("rstw_q0", q0, 32'h0);
        issue(0, 1, 0, 6'h3F, 32'h0);
        wait_done(0, "rd3f", 6, 1);
        release_req(0, "rd3f");
        issue(0, 1, 0, 6'h2A, 32'h0);
        wait_done(0, "rd2a_clr", 6, 1);
        release_req(0, "rd2a_clr");

        // Single-cycle latency instance: read+write together is a write.
        issue(1, 0, 1, 6'h01, 32'h11223344);
        wait_done(1, "l1_wr01", 2, 0);
        release_req(1, "l1_wr01");
        issue(1, 1, 0, 6'h01, 32'h0);
        wait_done(1, "l1_rd01", 2, 1);
        release_req(1, "l1_rd01");
        issue(1, 1, 1, 6'h00, 32'hCAFEF00D);
        wait_done(1, "l1_both", 2, 0);
        release_req(1, "l1_both");
        issue(1, 1, 0, 6'h00, 32'h0);
        wait_done(1, "l1_rd00", 2, 1);
        release_req(1, "l1_rd00");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_block.md
Name: data_memory_block

Overview:
- Main data memory sitting directly downstream of the data cache; serves whole 4-byte block reads and writes over the cache's mem_* interface.
- Models a multi-cycle DRAM access: holds mem_busywait high for a fixed latency, then commits the write or returns the read block.
- The completion cycle is followed by one turnaround cycle so the cache FSM can leave its MEM_READ / MEM_WRITE state without triggering a spurious re-request.

Parameters:
- ADDR_W, 6, block address width; 2**ADDR_W blocks.
- BLOCK_BYTES, 4, bytes per block; mem_writedata/mem_readdata width = 8*BLOCK_BYTES.
- ACCESS_CYCLES, 5, number of BUSY cycles per access; legal range 1..255.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- mem_read  input  1  block read request from cache.
- mem_write  input  1  block write request from cache.
- mem_address  input  ADDR_W  block address {tag,index}.
- mem_writedata  input  8*BLOCK_BYTES  block to write; bits [7:0] = byte offset 0.
- mem_readdata  output  8*BLOCK_BYTES  block read; bits [7:0] = byte offset 0; registered.
- mem_busywait  output  1  combinational stall to cache.

Behaviour:
- Clocking and reset: clk only, reset synchronous active-high (as decided). On reset:
  - state=IDLE, counter=0, mem_readdata=0, all storage bytes=0;
  - mem_busywait=0 from the first cycle after the reset edge.
- States:
  - IDLE: if mem_read|mem_write, mem_busywait=1 combinationally in the same cycle. At the posedge, latch op, mem_address and mem_writedata, load counter=ACCESS_CYCLES-1, go to BUSY. No request: stay.
  - BUSY: mem_busywait=1; inputs ignored (latched copies used); counter decrements each cycle. At the posedge where counter==0:
    - read: mem_readdata <= stored block;
    - write: each byte k <= latched_wdata[8k+7:8k] at byte address {addr,k};
    - then go to DONE.
  - DONE: mem_busywait=0; requests ignored; go to IDLE unconditionally.
- Timing, with request first seen in cycle 0: mem_busywait high in cycles 0..ACCESS_CYCLES, low in cycle ACCESS_CYCLES+1 (DONE). Read data valid from cycle ACCESS_CYCLES+1 and held until the next read completes. Write visible to any read accepted after DONE.
- Storage: byte array of 2**ADDR_W * BLOCK_BYTES bytes, little-endian within the block as above.
- mem_read & mem_write both high at acceptance: treated as write; mem_readdata unchanged.
- Request dropped during BUSY: the access still completes using latched values.
- mem_address or mem_writedata changing during BUSY: no effect.
- Reset during BUSY or DONE: access aborted, no write commit, storage cleared, state IDLE.
- mem_readdata changes only at a read completion or at reset.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - BLOCK_BYTES and ADDR_W defaults shared with the cache;
  - counter width constant (8 bits).
- One sub-module, data_mem_array: byte storage with a synchronous block write port, a synchronous block read port and synchronous clear.
- The FSM, latency counter and request latches live in data_memory_block.

Test Plan:
- Reset, then read block 6'h05 -> mem_busywait high 6 cycles (ACCESS_CYCLES=5), low in cycle 6; mem_readdata=32'h00000000.
- Write 6'h2A with 32'hDDCCBBAA, then read 6'h2A -> mem_readdata=32'hDDCCBBAA; byte address 168 holds 8'hAA and byte address 171 holds 8'hDD.
- Change mem_address to 6'h01 and mem_writedata to 32'h0 in cycle 2 of a write to 6'h10 with 32'h12345678 -> 6'h10 reads back 32'h12345678 and 6'h01 is unchanged.
- Cache-style back-to-back: mem_read held through the DONE cycle -> no second access starts in DONE; a request in the next IDLE cycle starts a fresh 6-cycle busywait.
- Reset asserted in cycle 3 of a write of 32'hFFFFFFFF to 6'h3F -> mem_busywait=0 after the reset edge; a later read of 6'h3F returns 32'h0.
- ACCESS_CYCLES=1, mem_read & mem_write both high with data 32'hCAFEF00D to 6'h00 -> busywait high 2 cycles; write wins; mem_readdata unchanged; a subsequent read returns 32'hCAFEF00D.
